// File: rtl/rv32i_mem1.sv
// rv32i_mem1: RV32I memory-access stage with a req/ack data port, byte-lane steering and load extension.
// Optional feature: define RV32I_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module rv32i_mem1 #(
   parameter int DM_AW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      res_d_op,
   input  logic [31:0]      res_brt_dma,
   input  logic [31:0]      st_d,
   input  logic [4:0]       rd_a,
   input  logic             wb_req,
   input  logic             is_ld,
   input  logic             is_st,
   input  logic [2:0]       ls_sz,
   output logic             dm_req,
   output logic             dm_we,
   output logic [DM_AW-1:0] dm_addr,
   output logic [3:0]       dm_be,
   output logic [31:0]      dm_wdata,
   input  logic             dm_ack,
   input  logic [31:0]      dm_rdata,
   output logic             wb_valid,
   output logic             wb_en,
   output logic [4:0]       wb_rd_a,
   output logic [31:0]      wb_d,
   output logic             exc_mis,
   output logic [31:0]      exc_addr
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Undefined funct3 width codes fall into the word class.
   function automatic logic [1:0] size_class(input logic [2:0] sz);
      case (sz)
         3'b000, 3'b100: return SZ_B;
         3'b001, 3'b101: return SZ_H;
         default:        return SZ_W;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] cls, input logic [1:0] off);
      case (cls)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] cls, input logic [31:0] d);
      case (cls)
         SZ_B:    return {4{d[7:0]}};
         SZ_H:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [1:0] cls, input logic uns,
                                            input logic [1:0] off, input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (cls)
         SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return rdata;
      endcase
   endfunction

   logic [0:0]       state_q, state_d;
   logic             dm_req_q, dm_req_d;
   logic             dm_we_q, dm_we_d;
   logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
   logic [3:0]       dm_be_q, dm_be_d;
   logic [31:0]      dm_wdata_q, dm_wdata_d;
   logic             wb_valid_q, wb_valid_d;
   logic             wb_en_q, wb_en_d;
   logic [4:0]       wb_rd_a_q, wb_rd_a_d;
   logic [31:0]      wb_d_q, wb_d_d;
   logic [1:0]       lat_cls_q, lat_cls_d;
   logic             lat_uns_q, lat_uns_d;
   logic [1:0]       lat_off_q, lat_off_d;
   logic             lat_ld_q, lat_ld_d;
   logic             lat_wen_q, lat_wen_d;
   logic [4:0]       lat_rd_q, lat_rd_d;

   logic [1:0]       in_cls;
   logic [1:0]       in_off;
   logic             is_mem;
   logic             acc_mis;

   assign in_cls = size_class(ls_sz);
   assign in_off = res_brt_dma[1:0];
   assign is_mem = is_ld | is_st;

   always_comb begin
`ifdef RV32I_MISALIGN_TRAP_EN
      acc_mis = ((in_cls == SZ_H) && in_off[0]) || ((in_cls == SZ_W) && (in_off != 2'b00));
`else
      acc_mis = 1'b0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_be_d    = dm_be_q;
      dm_wdata_d = dm_wdata_q;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      wb_rd_a_d  = wb_rd_a_q;
      wb_d_d     = wb_d_q;
      lat_cls_d  = lat_cls_q;
      lat_uns_d  = lat_uns_q;
      lat_off_d  = lat_off_q;
      lat_ld_d   = lat_ld_q;
      lat_wen_d  = lat_wen_q;
      lat_rd_d   = lat_rd_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_en_d    = wb_req & (rd_a != 5'd0);
                  wb_rd_a_d  = rd_a;
                  wb_d_d     = res_d_op;
               end else if (acc_mis) begin
                  // Trapped access retires at once without touching memory.
                  wb_valid_d = 1'b1;
                  wb_rd_a_d  = rd_a;
               end else begin
                  dm_req_d   = 1'b1;
                  dm_we_d    = is_st;
                  dm_addr_d  = {res_brt_dma[DM_AW-1:2], 2'b00};
                  dm_be_d    = lane_be(in_cls, in_off);
                  dm_wdata_d = lane_wdata(in_cls, st_d);
                  lat_cls_d  = in_cls;
                  lat_uns_d  = ls_sz[2];
                  lat_off_d  = in_off;
                  lat_ld_d   = is_ld;
                  lat_wen_d  = wb_req & is_ld & (rd_a != 5'd0);
                  lat_rd_d   = rd_a;
                  state_d    = S_BUSY;
               end
            end
         end
         default: begin
            if (dm_ack) begin
               dm_req_d   = 1'b0;
               wb_valid_d = 1'b1;
               wb_en_d    = lat_wen_q;
               wb_rd_a_d  = lat_rd_q;
               if (lat_ld_q) begin
                  wb_d_d = load_ext(lat_cls_q, lat_uns_q, lat_off_q, dm_rdata);
               end
               state_d    = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_be_q    <= 4'd0;
         dm_wdata_q <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_a_q  <= 5'd0;
         wb_d_q     <= 32'd0;
         lat_cls_q  <= SZ_B;
         lat_uns_q  <= 1'b0;
         lat_off_q  <= 2'd0;
         lat_ld_q   <= 1'b0;
         lat_wen_q  <= 1'b0;
         lat_rd_q   <= 5'd0;
      end else begin
         state_q    <= state_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_be_q    <= dm_be_d;
         dm_wdata_q <= dm_wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         wb_rd_a_q  <= wb_rd_a_d;
         wb_d_q     <= wb_d_d;
         lat_cls_q  <= lat_cls_d;
         lat_uns_q  <= lat_uns_d;
         lat_off_q  <= lat_off_d;
         lat_ld_q   <= lat_ld_d;
         lat_wen_q  <= lat_wen_d;
         lat_rd_q   <= lat_rd_d;
      end
   end

`ifdef RV32I_MISALIGN_TRAP_EN
   logic        exc_mis_q, exc_mis_d;
   logic [31:0] exc_addr_q, exc_addr_d;

   always_comb begin
      exc_mis_d  = (state_q == S_IDLE) && in_valid && is_mem && acc_mis;
      exc_addr_d = exc_mis_d ? res_brt_dma : exc_addr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_mis_q  <= 1'b0;
         exc_addr_q <= 32'd0;
      end else begin
         exc_mis_q  <= exc_mis_d;
         exc_addr_q <= exc_addr_d;
      end
   end

   assign exc_mis  = exc_mis_q;
   assign exc_addr = exc_addr_q;
`else
   assign exc_mis  = 1'b0;
   assign exc_addr = 32'd0;
`endif

   assign in_ready = (state_q == S_IDLE);
   assign dm_req   = dm_req_q;
   assign dm_we    = dm_we_q;
   assign dm_addr  = dm_addr_q;
   assign dm_be    = dm_be_q;
   assign dm_wdata = dm_wdata_q;
   assign wb_valid = wb_valid_q;
   assign wb_en    = wb_en_q;
   assign wb_rd_a  = wb_rd_a_q;
   assign wb_d     = wb_d_q;

endmodule

// File: tb/tb_rv32i_mem1.sv
// Scoreboard bench for rv32i_mem1: random instruction stream, reference memory responder and retire monitor.
module tb_rv32i_mem1;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] res_d_op;
   logic [31:0] res_brt_dma;
   logic [31:0] st_d;
   logic [4:0]  rd_a;
   logic        wb_req;
   logic        is_ld;
   logic        is_st;
   logic [2:0]  ls_sz;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        wb_valid;
   logic        wb_en;
   logic [4:0]  wb_rd_a;
   logic [31:0] wb_d;
   logic        exc_mis;
   logic [31:0] exc_addr;

   rv32i_mem1 #(.DM_AW(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .res_d_op(res_d_op), .res_brt_dma(res_brt_dma), .st_d(st_d), .rd_a(rd_a),
      .wb_req(wb_req), .is_ld(is_ld), .is_st(is_st), .ls_sz(ls_sz),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd_a(wb_rd_a), .wb_d(wb_d),
      .exc_mis(exc_mis), .exc_addr(exc_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] d;
      bit          chk_d;
      bit          exc;
      logic [31:0] eaddr;
   } ret_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      bit          ld;
      int          cls;
      bit          uns;
      logic [1:0]  off;
      logic [4:0]  rd;
      logic        wen;
      int          wt;
      bit          frd;
      logic [31:0] rdv;
   } req_t;

   ret_t exp_q[$];
   req_t req_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   spur_all = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference rules: 0 = byte, 1 = half, 2 = word (unknown codes behave as word).
   function automatic int m_cls(input logic [2:0] sz);
      if (sz == 3'd0 || sz == 3'd4) return 0;
      if (sz == 3'd1 || sz == 3'd5) return 1;
      return 2;
   endfunction

   function automatic logic [3:0] m_be(input int cls, input logic [1:0] a);
      if (cls == 0) return 4'(1 << a);
      if (cls == 1) return (a >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int cls, input logic [31:0] d);
      if (cls == 0) return d[7:0] * 32'h0101_0101;
      if (cls == 1) return d[15:0] * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input int cls, input bit uns, input logic [1:0] a,
                                          input logic [31:0] rdata);
      logic [31:0] v;
      if (cls == 0) begin
         v = (rdata >> (8 * a)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v - 32'd256;
         return v;
      end
      if (cls == 1) begin
         v = (rdata >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v - 32'd65536;
         return v;
      end
      return rdata;
   endfunction

   function automatic bit m_mis(input int cls, input logic [1:0] a);
`ifdef RV32I_MISALIGN_TRAP_EN
      return (cls == 1 && (a % 2) == 1) || (cls == 2 && a != 0);
`else
      return (cls < 0) && (a != a);
`endif
   endfunction

   // Issue one instruction; returns 1 time unit after the accepting edge.
   task automatic issue(input bit ld, input bit st, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] res, input logic [4:0] rd,
                        input bit wreq, input int wt, input bit frd, input logic [31:0] rdv);
      int   guard;
      ret_t r;
      req_t q;
      int   cls;
      guard       = 0;
      in_valid    = 1'b1;
      is_ld       = ld;
      is_st       = st;
      ls_sz       = sz;
      res_brt_dma = addr;
      st_d        = sd;
      res_d_op    = res;
      rd_a        = rd;
      wb_req      = wreq;
      while (in_ready !== 1'b1 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (in_ready !== 1'b1) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      cls = m_cls(sz);
      if (!ld && !st) begin
         r.en = wreq && (rd != 0); r.rd = rd; r.d = res; r.chk_d = 1'b1;
         r.exc = 1'b0; r.eaddr = 32'd0;
         exp_q.push_back(r);
      end else if (m_mis(cls, addr[1:0])) begin
         r.en = 1'b0; r.rd = rd; r.d = 32'd0; r.chk_d = 1'b0;
         r.exc = 1'b1; r.eaddr = addr;
         exp_q.push_back(r);
      end else begin
         q.addr = addr & 32'hFFFF_FFFC; q.be = m_be(cls, addr[1:0]); q.we = st;
         q.wdata = m_wdata(cls, sd); q.ld = ld; q.cls = cls; q.uns = (sz == 3'd4 || sz == 3'd5);
         q.off = addr[1:0]; q.rd = rd; q.wen = wreq && ld && (rd != 0);
         q.wt = wt; q.frd = frd; q.rdv = rdv;
         req_q.push_back(q);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_retire(input string nm);
      int g;
      g = 0;
      while (wb_valid !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (wb_valid !== 1'b1) chk({nm, "_retire_timeout"}, 32'd0, 32'd1);
   endtask

   // Memory responder: checks each request against the model and completes it after a wait.
   initial begin : responder
      bit   active;
      int   waits;
      req_t cur;
      ret_t r;
      active   = 1'b0;
      waits    = 0;
      dm_ack   = 1'b0;
      dm_rdata = 32'd0;
      forever begin
         @(negedge clk);
         dm_ack = 1'b0;
         if (dm_req === 1'b1) begin
            chk("in_ready_busy", in_ready, 32'd0);
            if (!active) begin
               chk("req_expected", req_q.size() != 0, 32'd1);
               if (req_q.size() != 0) begin
                  cur    = req_q.pop_front();
                  active = 1'b1;
                  waits  = (cur.wt >= 0) ? cur.wt : int'($urandom_range(0, 3));
               end
            end
            if (active) begin
               chk("dm_addr", dm_addr, cur.addr);
               chk("dm_be", dm_be, cur.be);
               chk("dm_we", dm_we, cur.we);
               if (cur.we) chk("dm_wdata", dm_wdata, cur.wdata);
               if (waits == 0) begin
                  dm_rdata = cur.frd ? cur.rdv : $urandom;
                  dm_ack   = 1'b1;
                  active   = 1'b0;
                  r.en = cur.wen; r.rd = cur.rd; r.chk_d = cur.ld;
                  r.d = cur.ld ? m_load(cur.cls, cur.uns, cur.off, dm_rdata) : 32'd0;
                  r.exc = 1'b0; r.eaddr = 32'd0;
                  exp_q.push_back(r);
               end else begin
                  waits--;
               end
            end
         end else begin
            active = 1'b0;
            if (spur_all || $urandom_range(0, 3) == 0) begin
               dm_ack   = 1'b1;
               dm_rdata = $urandom;
            end
         end
      end
   end

   // Retire monitor: every wb_valid pulse must match the oldest expected retire.
   initial begin : monitor
      ret_t e;
      forever begin
         @(negedge clk);
         if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", wb_valid, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wb_en", wb_en, e.en);
               chk("wb_rd_a", wb_rd_a, e.rd);
               if (e.chk_d) chk("wb_d", wb_d, e.d);
               chk("exc_mis", exc_mis, e.exc);
               if (e.exc) chk("exc_addr", exc_addr, e.eaddr);
            end
         end else if (wb_valid !== 1'b0) begin
            chk("wb_valid_known", wb_valid, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [2:0] szs [8];
      int         g;
      szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      rst_n = 1'b0; in_valid = 1'b0; is_ld = 1'b0; is_st = 1'b0; ls_sz = 3'd0;
      res_brt_dma = 32'd0; st_d = 32'd0; res_d_op = 32'd0; rd_a = 5'd0; wb_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 32'd1);
      chk("rst_dm_req", dm_req, 32'd0);
      chk("rst_dm_we", dm_we, 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_be", dm_be, 32'd0);
      chk("rst_dm_wdata", dm_wdata, 32'd0);
      chk("rst_wb_valid", wb_valid, 32'd0);
      chk("rst_wb_en", wb_en, 32'd0);
      chk("rst_wb_rd_a", wb_rd_a, 32'd0);
      chk("rst_wb_d", wb_d, 32'd0);
      chk("rst_exc_mis", exc_mis, 32'd0);
      chk("rst_exc_addr", exc_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU op then back-to-back ALU ops, each retiring the cycle after accept.
      issue(0, 0, 3'd2, 32'd0, 32'd0, 32'h0000_1234, 5'd5, 1, -1, 0, 32'd0);
      chk("add_valid", wb_valid, 32'd1);
      chk("add_en", wb_en, 32'd1);
      chk("add_rd", wb_rd_a, 32'd5);
      chk("add_d", wb_d, 32'h0000_1234);
      for (int i = 0; i < 4; i++) begin
         issue(0, 0, 3'd2, 32'd0, 32'd0, $urandom, 5'($urandom), 1'($urandom), -1, 0, 32'd0);
         chk("b2b_valid", wb_valid, 32'd1);
      end

      // LB / LBU at 0x1003 with three wait cycles.
      issue(1, 0, 3'd0, 32'h1003, 32'd0, 32'd0, 5'd7, 1, 3, 1, 32'h80AB_CDEF);
      chk("lb_be", dm_be, 32'h8);
      chk("lb_addr", dm_addr, 32'h1000);
      wait_retire("lb");
      chk("lb_d", wb_d, 32'hFFFF_FF80);
      issue(1, 0, 3'd4, 32'h1003, 32'd0, 32'd0, 5'd7, 1, 3, 1, 32'h80AB_CDEF);
      wait_retire("lbu");
      chk("lbu_d", wb_d, 32'h0000_0080);

      // SH with zero-wait ack.
      @(negedge clk);
      issue(0, 1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 32'd0, 5'd3, 1, 0, 0, 32'd0);
      chk("sh_we", dm_we, 32'd1);
      chk("sh_be", dm_be, 32'hC);
      chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
      wait_retire("sh");
      chk("sh_en", wb_en, 32'd0);

      // LW to x0 and stray acks while idle.
      @(negedge clk);
      issue(1, 0, 3'd2, 32'h3000, 32'd0, 32'd0, 5'd0, 1, 1, 0, 32'd0);
      wait_retire("lw_x0");
      chk("lw_x0_en", wb_en, 32'd0);
      spur_all = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ack_no_retire", wb_valid, 32'd0);
      end
      spur_all = 1'b0;

      // Reset while busy abandons the access.
      issue(1, 0, 3'd2, 32'h0000_0040, 32'd0, 32'd0, 5'd9, 1, 8, 0, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy_req", dm_req, 32'd0);
      chk("rst_busy_valid", wb_valid, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(1, 0, 3'd2, 32'h0, 32'd0, 32'd0, 5'd4, 1, 1, 1, 32'h1234_5678);
      wait_retire("lw_after_rst");
      chk("lw_after_rst_d", wb_d, 32'h1234_5678);
      chk("lw_after_rst_en", wb_en, 32'd1);

      // Misaligned word access.
      @(negedge clk);
      issue(1, 0, 3'd2, 32'h1002, 32'd0, 32'd0, 5'd6, 1, 0, 1, 32'hCAFE_F00D);
`ifdef RV32I_MISALIGN_TRAP_EN
      chk("mis_no_req", dm_req, 32'd0);
      chk("mis_exc", exc_mis, 32'd1);
      chk("mis_addr", exc_addr, 32'h1002);
`else
      chk("mis_addr_al", dm_addr, 32'h1000);
      chk("mis_be", dm_be, 32'hF);
      wait_retire("lw_mis");
      chk("lw_mis_d", wb_d, 32'hCAFE_F00D);
`endif

      // Random instruction stream.
      for (int i = 0; i < 300; i++) begin
         int k;
         k = int'($urandom_range(0, 9));
         if (k < 4) begin
            issue(0, 0, 3'd0, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), -1, 0, 32'd0);
         end else if (k < 7) begin
            issue(1, 0, szs[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                  5'($urandom), 1'($urandom), -1, 0, 32'd0);
         end else begin
            issue(0, 1, szs[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                  5'($urandom), 1'($urandom), -1, 0, 32'd0);
         end
      end

      g = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0 || dm_req === 1'b1) && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain_exp", exp_q.size(), 32'd0);
      chk("drain_req", req_q.size(), 32'd0);
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32i_mem1.md
# rv32i_mem1

Memory-access stage of the RV32I pipeline, directly downstream of `rv32i_ex1`. It consumes the ALU result and the memory address computed by the execute stage and runs loads and stores over a req/ack data-memory port, including byte-lane steering and load sign/zero extension. It stalls upstream while a transaction is outstanding and presents one registered result per instruction to write-back.

## Interface
Parameters:
- `DM_AW`, default 32: data-memory address width. `dm_addr` carries the low `DM_AW` bits, with bits [1:0] forced to 0.

Ports. One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: the execute stage is presenting an instruction.
- `in_ready` out 1: the stage accepts on this cycle (`in_valid & in_ready` at an edge means the instruction is accepted).
- `res_d_op` in 32: ALU result; this is the write-back data for non-memory instructions.
- `res_brt_dma` in 32: byte address for the memory access.
- `st_d` in 32: store data (rs2).
- `rd_a` in 5: destination register.
- `wb_req` in 1: the instruction writes a register.
- `is_ld`, `is_st` in 1 each: load or store; never both high together.
- `ls_sz` in 3: funct3 width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `dm_req` out 1: a memory request is pending.
- `dm_we` out 1: the request is a write.
- `dm_addr` out `DM_AW`: word-aligned address.
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: memory completes the request on this edge.
- `dm_rdata` in 32: read word; valid when `dm_ack` is high.
- `wb_valid` out 1: one-cycle retire pulse.
- `wb_en` out 1: write-enable for the register file.
- `wb_rd_a` out 5: write-back register address.
- `wb_d` out 32: write-back data.
- `exc_mis` out 1: misaligned-access pulse.
- `exc_addr` out 32: faulting address.

## Operation
The stage is a state machine with two states, IDLE and BUSY. `in_ready` = (state == IDLE).

In IDLE, on accept:
- Non-memory instruction: `wb_d`←`res_d_op`, `wb_en`←`wb_req & (rd_a≠0)`, `wb_valid`←1. The state stays IDLE.
- Memory instruction: latch the address, size, data and `rd_a`. Set `dm_req`←1 and `dm_we`←`is_st`, drive `dm_addr`, `dm_be` and `dm_wdata`, then go to BUSY.

In BUSY:
- `dm_req`, `dm_we`, `dm_addr`, `dm_be` and `dm_wdata` are held stable.
- On `dm_ack`: `dm_req`←0 and `wb_valid`←1, then return to IDLE.
- For a load, `wb_d` is the extracted lane, extended as follows: B and H sign-extend, BU and HU zero-extend, W is passed unchanged.
- `wb_en` = `wb_req & is_ld & (rd_a≠0)`. A store always retires with `wb_en`=0.

Byte lanes (a = address[1:0]):
- B: `dm_be`=0001<<a, `dm_wdata`={4{st_d[7:0]}}.
- H: `dm_be`=a[1]?1100:0011, `dm_wdata`={2{st_d[15:0]}}.
- W: `dm_be`=1111, `dm_wdata`=`st_d`.
- Reads drive the same `dm_be` pattern.
- Any undefined `ls_sz` code is treated as W.

Boundary conditions:
- `dm_ack` in IDLE is ignored.
- `in_valid` while BUSY is ignored; upstream must hold its inputs.
- `dm_ack` in the first BUSY cycle (zero-wait memory) is legal.
- `wb_valid` and `exc_mis` self-clear after one cycle.

## Timing
Reset values: state IDLE, `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_be`=0, `dm_wdata`=0, `wb_valid`=0, `wb_en`=0, `wb_rd_a`=0, `wb_d`=0, `exc_mis`=0, `exc_addr`=0.

Latency:
- Non-memory instruction: accept at edge E0, `wb_valid` high for the cycle after E0. Throughput is one per cycle.
- Memory access: accept at E0, `dm_req` high after E0, `dm_ack` sampled at E1 or later (first ack edge Ek), `wb_valid` high for the cycle after Ek. Minimum 2 edges from accept to retire.
- `in_ready` returns high in the cycle after Ek, so a new accept can occur at Ek+1.

Reset mid-transaction: `dm_req` drops immediately (asynchronously), the access is abandoned and no retire is produced.

## Configuration
`RV32I_MISALIGN_TRAP_EN`:
- Defined: an H access with a[0]=1, or a W access with a≠00, issues no memory request. The state stays IDLE. In the cycle after accept, `exc_mis`=1, `exc_addr`=address, and `wb_valid`=1 with `wb_en`=0.
- Undefined: `exc_mis` and `exc_addr` are tied to 0. H uses a[1] only and W ignores a[1:0], so the access proceeds normally.

## Test plan
- ADD result 0x0000_1234, rd=5 → one cycle after accept: `wb_valid`=1, `wb_en`=1, `wb_rd_a`=5, `wb_d`=0x0000_1234; back-to-back ALU ops retire every cycle.
- LB at 0x1003, `dm_rdata`=0x80xx_xxxx, ack after 3 wait cycles → `dm_be`=1000, `dm_addr`=0x1000, `in_ready` low throughout, `wb_d`=0xFFFF_FF80; the same access with LBU → 0x0000_0080.
- SH at 0x2002, `st_d`=0xDEAD_BEEF, zero-wait ack → `dm_we`=1, `dm_be`=1100, `dm_wdata`=0xBEEF_BEEF, retire with `wb_en`=0.
- LW to rd=0 → the access completes but `wb_en`=0; a second `dm_ack` while IDLE causes no retire.
- `rst_n` asserted while BUSY → `dm_req`=0 immediately and no `wb_valid`; after release, an LW at 0x0 completes normally.
- LW at 0x1002: with `RV32I_MISALIGN_TRAP_EN` → no `dm_req`, `exc_mis`=1, `exc_addr`=0x1002; without it → `dm_addr`=0x1000, `dm_be`=1111, normal load.
